// File: rtl/piso_frame_rx_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package piso_rx_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } rx_state_e;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/piso_frame_rx_bit_sync.sv
// Two-flop synchronizer with configurable reset level; holds while enb is low.
module bit_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic enb,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Two-stage capture of the asynchronous line
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= RST_VAL;
         sync_r <= RST_VAL;
      end else if (enb) begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/piso_frame_rx.sv
// Serial frame receiver: start/payload(MSB first)/stop, mid-bit sampling,
// payload output with one-cycle valid and framing-error strobes.
module piso_frame_rx
   import piso_rx_pkg::*;
#(
   parameter int DW           = 10,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enb,
   input  logic          serial_in,
   output logic [DW-3:0] rx_data,
   output logic          rx_valid,
   output logic          frame_err,
   output logic          busy
);

   localparam int PW = DW - 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (PW > 1) ? $clog2(PW) : 1;

   localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] IDX_LAST = BW'(PW - 1);

   rx_state_e         state_r;
   logic [CW-1:0]     cnt_r;
   logic [BW-1:0]     bit_idx_r;
   logic [PW-1:0]     shreg_r;
   logic              rx_s;

   bit_sync #(
      .RST_VAL (IDLE_LVL)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .enb   (enb),
      .d     (serial_in),
      .q     (rx_s)
   );

   assign busy = (state_r != IDLE);

   // Frame FSM: bit timing, payload assembly and registered strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         bit_idx_r <= '0;
         shreg_r   <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else if (enb) begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (state_r)
            IDLE: begin
               if (rx_s == START_BIT) begin
                  state_r <= START;
                  cnt_r   <= '0;
               end
            end
            START: begin
               // Re-check at mid start bit so short glitches are rejected
               if (cnt_r == CNT_MID) begin
                  cnt_r <= '0;
                  if (rx_s == START_BIT) begin
                     state_r   <= DATA;
                     bit_idx_r <= '0;
                  end else begin
                     state_r <= IDLE;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            DATA: begin
               if (cnt_r == CNT_LAST) begin
                  cnt_r   <= '0;
                  shreg_r <= {shreg_r[PW-2:0], rx_s};
                  if (bit_idx_r == IDX_LAST) begin
                     state_r <= STOP;
                  end else begin
                     bit_idx_r <= bit_idx_r + BW'(1);
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            STOP: begin
               if (cnt_r == CNT_LAST) begin
                  cnt_r <= '0;
                  if (rx_s == STOP_BIT) begin
                     rx_data  <= shreg_r;
                     rx_valid <= 1'b1;
                     state_r  <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state_r   <= WAIT_IDLE;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            // A held-low (break) line must not decode as repeated frames
            WAIT_IDLE: begin
               if (rx_s == IDLE_LVL) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_frame_rx.sv
// Randomized scoreboard bench for piso_frame_rx with a frame-level reference model.
module tb_piso_frame_rx;

   localparam int DW    = 10;
   localparam int CPB   = 4;
   localparam int PW    = DW - 2;
   localparam int LAT   = 2 + CPB / 2 + (DW - 1) * CPB;
   localparam int PAUSE = 7;

   typedef struct {
      logic          err;
      logic [PW-1:0] data;
      int            cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          enb;
   logic          serial_in;
   logic [PW-1:0] rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic          busy;

   int            cyc = 0;
   int            n_checks = 0;
   int            n_pass = 0;
   exp_t          exp_q[$];
   logic [PW-1:0] last_data = '0;

   piso_frame_rx #(
      .DW           (DW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enb       (enb),
      .serial_in (serial_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
   endtask

   // Monitor: every strobe must match the oldest expected frame outcome
   always @(negedge clk) begin
      if (reset === 1'b0 && (rx_valid || frame_err)) begin
         chk("strobe_exclusive", int'(rx_valid & frame_err), 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", exp_q.size(), 1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("strobe_kind", int'(frame_err), int'(e.err));
            chk("strobe_data", int'(rx_data), int'(e.data));
            chk("strobe_time", cyc, e.cyc);
         end
      end
   end

   task automatic idle_bits(input int nbits);
      repeat (nbits * CPB) begin
         @(negedge clk);
         serial_in = 1'b1;
      end
   endtask

   // Drive one frame; pause_at >= 0 freezes enb for PAUSE cycles at that frame cycle
   task automatic send_frame(input logic [PW-1:0] d, input logic stop_b, input int pause_at);
      logic [DW-1:0] fr;
      exp_t          e;
      fr = {1'b0, d, stop_b};
      for (int j = 0; j < DW * CPB; j++) begin
         @(negedge clk);
         serial_in = fr[DW-1-j/CPB];
         if (j == 0) begin
            e.err  = !stop_b;
            e.data = stop_b ? d : last_data;
            e.cyc  = cyc + 1 + LAT + ((pause_at >= 0) ? PAUSE : 0);
            exp_q.push_back(e);
            if (stop_b) last_data = d;
         end
         if (j == pause_at) begin
            enb = 1'b0;
            repeat (PAUSE) @(negedge clk);
            enb = 1'b1;
         end
      end
   endtask

   initial begin
      int busy_cnt;
      int budget;
      logic [DW-1:0] fr;
      reset     = 1'b1;
      enb       = 1'b1;
      serial_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_rx_data", int'(rx_data), 0);
      chk("reset_rx_valid", int'(rx_valid), 0);
      chk("reset_frame_err", int'(frame_err), 0);
      chk("reset_busy", int'(busy), 0);
      reset = 1'b0;
      idle_bits(2);

      // Basic frame, then back-to-back pair
      send_frame(8'hA5, 1'b1, -1);
      idle_bits(2);
      send_frame(8'h3C, 1'b1, -1);
      send_frame(8'hFF, 1'b1, -1);
      idle_bits(2);

      // Bad stop bit followed by a long break
      send_frame(8'h81, 1'b0, -1);
      repeat (20 * CPB) begin
         @(negedge clk);
         serial_in = 1'b0;
      end
      chk("busy_during_break", int'(busy), 1);
      @(negedge clk);
      serial_in = 1'b1;
      repeat (2) @(negedge clk);
      chk("busy_before_idle", int'(busy), 1);
      @(negedge clk);
      chk("busy_after_idle", int'(busy), 0);
      idle_bits(2);

      // One-cycle glitch on an idle line
      @(negedge clk);
      serial_in = 1'b0;
      @(negedge clk);
      serial_in = 1'b1;
      busy_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      chk("glitch_busy_cycles", busy_cnt, 2);
      idle_bits(2);

      // Reset during data bit 4, held until the frame has passed
      fr = {1'b0, 8'h55, 1'b1};
      for (int j = 0; j < DW * CPB; j++) begin
         @(negedge clk);
         serial_in = fr[DW-1-j/CPB];
         if (j == 4 * CPB + 1) reset = 1'b1;
         if (j == 4 * CPB + 2) begin
            chk("midreset_busy", int'(busy), 0);
            chk("midreset_rx_data", int'(rx_data), 0);
         end
      end
      reset     = 1'b0;
      last_data = '0;
      idle_bits(2);
      send_frame(8'h12, 1'b1, -1);
      idle_bits(2);

      // enb pause mid-frame
      send_frame(8'hC3, 1'b1, 5 * CPB + 1);
      idle_bits(2);

      // Randomized frames with random gaps and pauses
      for (int k = 0; k < 12; k++) begin
         logic [PW-1:0] d;
         int            pa;
         d  = PW'($urandom_range(0, (1 << PW) - 1));
         pa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(CPB, DW * CPB - 2)) : -1;
         send_frame(d, 1'b1, pa);
         idle_bits(int'($urandom_range(0, 3)));
      end

      budget = 0;
      while (exp_q.size() != 0 && budget < 200) begin
         @(negedge clk);
         serial_in = 1'b1;
         budget++;
      end
      chk("all_expected_seen", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/piso_frame_rx.md
Name: piso_frame_rx

Overview:
- Receive side of the serial link driven by the team's MSB-first PISO stage.
- Samples the single-bit serial line, detects frame start, reassembles the DW-bit frame MSB-first, checks framing and presents the payload word with a one-cycle valid strobe.
- Line idles high. Frame on the wire, MSB first: start bit (0), payload D[DW-3] down to D[0], stop bit (1).
- Sits between the serial line and the parallel consumer logic.

Parameters:
- DW, 10, total frame bits including start and stop; payload width PW = DW-2.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- enb  input  1  enable; when low all state, counters and outputs hold
- serial_in  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  DW-2  last correctly framed payload
- rx_valid  output  1  one-cycle strobe: rx_data updated this cycle
- frame_err  output  1  one-cycle strobe: stop bit sampled low
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - rx_data = 0; rx_valid = 0; frame_err = 0; busy = 0
  - state = IDLE; counters = 0
  - synchronizer flops = 1 (idle line)
- Input synchronizer: serial_in passes through 2 flops to give rx_s. This adds 2 cycles of latency. The FSM only uses rx_s.
- enb = 0 freezes everything, including the synchronizer, counters and state. Any strobe that would fire is deferred until enb returns high.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - At an edge where rx_s = 0 -> START, cnt = 0. Call this edge E0.
- START:
  - cnt increments each cycle.
  - When cnt = CLKS_PER_BIT/2-1, this is the mid-start sample (edge E0+CLKS_PER_BIT/2).
  - If rx_s = 0 -> DATA, cnt = 0, bit_idx = 0.
  - If rx_s = 1 (glitch) -> IDLE, no strobe.
- DATA:
  - When cnt = CLKS_PER_BIT-1: shreg <= {shreg[PW-2:0], rx_s}, cnt = 0, bit_idx++.
  - After the sample with bit_idx = PW-1 -> STOP.
  - Otherwise cnt increments.
  - Data bit k (k = 1..PW) is sampled at edge E0+CLKS_PER_BIT/2+k*CLKS_PER_BIT.
- STOP:
  - When cnt = CLKS_PER_BIT-1, sample at edge E0+CLKS_PER_BIT/2+(DW-1)*CLKS_PER_BIT.
  - If rx_s = 1: rx_data <= shreg and rx_valid = 1 for the following cycle -> IDLE.
  - If rx_s = 0: frame_err = 1 for the following cycle, rx_data unchanged -> WAIT_IDLE.
- WAIT_IDLE:
  - Stays until rx_s = 1, then -> IDLE. This prevents a held-low (break) line from being decoded as repeated frames.
- Back-to-back frames: IDLE is re-entered at mid-stop. A start edge arriving a half bit later is accepted without loss.
- rx_valid and frame_err are never both high.
- Strobes are registered, so each lasts exactly one enabled cycle.
- busy is combinational from state (state != IDLE).
- Reset mid-frame: at the next edge, return to IDLE with all outputs at reset values. The partial frame is discarded and no strobe is issued.
- Widths:
  - cnt is $clog2(CLKS_PER_BIT) bits.
  - bit_idx is $clog2(PW) bits; it never wraps past PW-1.

Decomposition:
- Package piso_rx_pkg holds:
  - state enum rx_state_e (IDLE, START, DATA, STOP, WAIT_IDLE)
  - START_BIT = 1'b0, STOP_BIT = 1'b1, IDLE_LVL = 1'b1
- Sub-module bit_sync: 2-flop synchronizer with a reset value parameter and an enb hold.
- Everything else (FSM, counters, shift register) lives in piso_frame_rx.

Test Plan:
- DW = 10, CLKS_PER_BIT = 4, serial_in driven with bit period 4 cycles. Apply frame 0 1010_0101 1 -> rx_valid one cycle, rx_data = 8'hA5, frame_err = 0. rx_valid rises 2+2+36+1 cycles after the serial_in falling edge.
- Two frames 8'h3C and 8'hFF back-to-back with no idle gap -> two rx_valid strobes with rx_data = 8'h3C then 8'hFF, nothing dropped.
- Frame 8'h81 with stop bit = 0, line then held low for 20 bit times -> a single frame_err strobe, rx_data keeps its previous value, busy stays high until the line returns high, then IDLE.
- 1-cycle low glitch on an idle line -> START rejects it and returns to IDLE; no rx_valid or frame_err; busy high for 2 cycles only.
- reset asserted at data bit 4 of a frame with payload 8'h55 -> next cycle busy = 0 and rx_data = 0; the remaining bits are ignored; the next full frame 8'h12 is received correctly.
- enb low for 7 cycles in the middle of a frame, with the serial stimulus paused in step -> 8'hC3 received correctly, and strobe timing shifts by exactly 7 cycles.
